// File: rtl/pwm_multi_pkg.sv
// Shared encodings for the multi-channel PWM block.
// Mode and counter direction enums used by the top and timebase.
package pwm_multi_pkg;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, up or up/down counter, frame boundary.
// Counter state sits at ctr = 0, dir = up while enable is low.
module pwm_timebase
    import pwm_multi_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [WIDTH-1:0]   period,
    input  logic [PRESC_W-1:0] presc,
    input  mode_e              mode,
    output logic [WIDTH-1:0]   ctr,
    output logic               boundary
);

    localparam logic [WIDTH-1:0]   C_ONE = WIDTH'(1);
    localparam logic [PRESC_W-1:0] P_ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] presc_cnt;
    logic [PRESC_W-1:0] cnt_d;
    logic [WIDTH-1:0]   ctr_d;
    dir_e               dir;
    dir_e               dir_d;
    logic               tick;
    logic               at_top;

    assign tick   = (presc_cnt == presc);
    assign at_top = (ctr == period);

    always_comb begin
        cnt_d    = presc_cnt + P_ONE;
        ctr_d    = ctr;
        dir_d    = dir;
        boundary = 1'b0;
        if (!enable) begin
            cnt_d = '0;
            ctr_d = '0;
            dir_d = DIR_UP;
        end else if (tick) begin
            cnt_d = '0;
            unique case (1'b1)
                (mode == MODE_EDGE): begin
                    dir_d = DIR_UP;
                    if (at_top) begin
                        ctr_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        ctr_d = ctr + C_ONE;
                    end
                end
                (mode == MODE_CENTER && dir == DIR_UP): begin
                    if (!at_top) begin
                        ctr_d = ctr + C_ONE;
                    end else if (period <= C_ONE) begin
                        // too short to turn around: restart as a plain wrap
                        ctr_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        ctr_d = period - C_ONE;
                        dir_d = DIR_DOWN;
                    end
                end
                (mode == MODE_CENTER && dir == DIR_DOWN): begin
                    if (ctr == C_ONE) begin
                        ctr_d    = '0;
                        dir_d    = DIR_UP;
                        boundary = 1'b1;
                    end else begin
                        ctr_d = ctr - C_ONE;
                    end
                end
                default: begin
                    ctr_d = '0;
                    dir_d = DIR_UP;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
            ctr       <= '0;
            dir       <= DIR_UP;
        end else begin
            presc_cnt <= cnt_d;
            ctr       <= ctr_d;
            dir       <= dir_d;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: staged/shadowed config, shared timebase, NCH comparators.
// Optional `PWM_POLARITY_EN adds per-channel output polarity (pol_in, pol_we).
module pwm_multi
    import pwm_multi_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NCH     = 4,
    parameter int CH_W    = 2,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [WIDTH-1:0]   period_in,
    input  logic               period_we,
    input  logic [PRESC_W-1:0] presc_in,
    input  logic               presc_we,
    input  logic               mode_in,
    input  logic               mode_we,
    input  logic [WIDTH-1:0]   duty_in,
    input  logic [CH_W-1:0]    duty_sel,
    input  logic               duty_we,
    output logic [NCH-1:0]     pwm_out,
    output logic               frame_start
`ifdef PWM_POLARITY_EN
    ,
    input  logic [NCH-1:0]     pol_in,
    input  logic               pol_we
`endif
);

    logic [WIDTH-1:0]   period_st;
    logic [WIDTH-1:0]   period_sh;
    logic [PRESC_W-1:0] presc_st;
    logic [PRESC_W-1:0] presc_sh;
    mode_e              mode_st;
    mode_e              mode_sh;
    logic [WIDTH-1:0]   duty_st [NCH];
    logic [WIDTH-1:0]   duty_sh [NCH];
    logic [WIDTH-1:0]   ctr;
    logic               boundary;
    logic               load;
    logic [NCH-1:0]     pwm_d;

    // disabled: shadows follow staging so a fresh enable sees latest writes
    assign load = boundary | ~enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_st <= '1;
            presc_st  <= '0;
            mode_st   <= MODE_EDGE;
            for (int i = 0; i < NCH; i++) begin
                duty_st[i] <= '0;
            end
        end else begin
            if (period_we) begin
                period_st <= period_in;
            end
            if (presc_we) begin
                presc_st <= presc_in;
            end
            if (mode_we) begin
                mode_st <= mode_e'(mode_in);
            end
            for (int i = 0; i < NCH; i++) begin
                if (duty_we && duty_sel == CH_W'(i)) begin
                    duty_st[i] <= duty_in;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_sh <= '1;
            presc_sh  <= '0;
            mode_sh   <= MODE_EDGE;
            for (int i = 0; i < NCH; i++) begin
                duty_sh[i] <= '0;
            end
        end else if (load) begin
            period_sh <= period_st;
            presc_sh  <= presc_st;
            mode_sh   <= mode_st;
            for (int i = 0; i < NCH; i++) begin
                duty_sh[i] <= duty_st[i];
            end
        end
    end

`ifdef PWM_POLARITY_EN
    logic [NCH-1:0] pol_st;
    logic [NCH-1:0] pol_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pol_st <= '0;
            pol_sh <= '0;
        end else begin
            if (pol_we) begin
                pol_st <= pol_in;
            end
            if (load) begin
                pol_sh <= pol_st;
            end
        end
    end
`endif

    pwm_timebase #(
        .WIDTH   (WIDTH),
        .PRESC_W (PRESC_W)
    ) u_tb (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .period   (period_sh),
        .presc    (presc_sh),
        .mode     (mode_sh),
        .ctr      (ctr),
        .boundary (boundary)
    );

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic hit;
        assign hit = enable & (ctr < duty_sh[g]);
`ifdef PWM_POLARITY_EN
        assign pwm_d[g] = hit ^ pol_sh[g];
`else
        assign pwm_d[g] = hit;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            pwm_out     <= pwm_d;
            frame_start <= boundary;
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: frame-position reference model,
// directed scenarios followed by randomized register traffic.
module tb_pwm_multi;

    localparam int WIDTH   = 8;
    localparam int NCH     = 3;
    localparam int CH_W    = 2;
    localparam int PRESC_W = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               enable = 1'b0;
    logic [WIDTH-1:0]   period_in = '0;
    logic               period_we = 1'b0;
    logic [PRESC_W-1:0] presc_in = '0;
    logic               presc_we = 1'b0;
    logic               mode_in = 1'b0;
    logic               mode_we = 1'b0;
    logic [WIDTH-1:0]   duty_in = '0;
    logic [CH_W-1:0]    duty_sel = '0;
    logic               duty_we = 1'b0;
    logic [NCH-1:0]     pol_in = '0;
    logic               pol_we = 1'b0;
    logic [NCH-1:0]     pwm_out;
    logic               frame_start;

    pwm_multi #(
        .WIDTH   (WIDTH),
        .NCH     (NCH),
        .CH_W    (CH_W),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .period_in   (period_in),
        .period_we   (period_we),
        .presc_in    (presc_in),
        .presc_we    (presc_we),
        .mode_in     (mode_in),
        .mode_we     (mode_we),
        .duty_in     (duty_in),
        .duty_sel    (duty_sel),
        .duty_we     (duty_we),
        .pwm_out     (pwm_out),
        .frame_start (frame_start)
`ifdef PWM_POLARITY_EN
        ,
        .pol_in      (pol_in),
        .pol_we      (pol_we)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] pwm;
        logic           fs;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // staged and active configuration as seen by the model
    int st_period, st_presc, st_mode;
    int sh_period, sh_presc, sh_mode;
    int st_duty [NCH];
    int sh_duty [NCH];
    int st_pol  [NCH];
    int sh_pol  [NCH];
    int pos;

    function automatic void model_reset();
        st_period = (1 << WIDTH) - 1;
        sh_period = st_period;
        st_presc = 0;
        sh_presc = 0;
        st_mode = 0;
        sh_mode = 0;
        for (int i = 0; i < NCH; i++) begin
            st_duty[i] = 0;
            sh_duty[i] = 0;
            st_pol[i] = 0;
            sh_pol[i] = 0;
        end
        pos = 0;
    endfunction

    // position within the frame in clk cycles -> counter value
    function automatic void model_step();
        int ticks, flen, k, c;
        bit bnd;
        exp_t e;
        if (sh_mode != 0)
            ticks = (sh_period == 0) ? 1 : 2 * sh_period;
        else
            ticks = sh_period + 1;
        flen = (sh_presc + 1) * ticks;
        k = pos / (sh_presc + 1);
        c = (sh_mode == 0 || k <= sh_period) ? k : 2 * sh_period - k;
        bnd = enable && (pos == flen - 1);
        for (int i = 0; i < NCH; i++) begin
            e.pwm[i] = enable && (c < sh_duty[i]);
`ifdef PWM_POLARITY_EN
            e.pwm[i] = e.pwm[i] ^ sh_pol[i][0];
`endif
        end
        e.fs = bnd;
        q.push_back(e);
        if (!enable || bnd) begin
            sh_period = st_period;
            sh_presc = st_presc;
            sh_mode = st_mode;
            for (int i = 0; i < NCH; i++) begin
                sh_duty[i] = st_duty[i];
                sh_pol[i] = st_pol[i];
            end
            pos = 0;
        end else begin
            pos = pos + 1;
        end
        if (period_we) st_period = int'(period_in);
        if (presc_we) st_presc = int'(presc_in);
        if (mode_we) st_mode = int'(mode_in);
        if (duty_we && int'(duty_sel) < NCH)
            st_duty[duty_sel] = int'(duty_in);
        if (pol_we)
            for (int i = 0; i < NCH; i++) st_pol[i] = int'(pol_in[i]);
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (pwm_out !== e.pwm || frame_start !== e.fs) begin
                    n_err++;
                    $display("FAIL cycle t=%0t pwm_out=%b frame_start=%b required pwm_out=%b frame_start=%b",
                             $time, pwm_out, frame_start, e.pwm, e.fs);
                end
            end
        end
    end

    function automatic void clr();
        period_we = 1'b0;
        presc_we = 1'b0;
        mode_we = 1'b0;
        duty_we = 1'b0;
        pol_we = 1'b0;
    endfunction

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            clr();
        end
    endtask

    task automatic wr_period(int v);
        @(negedge clk);
        clr();
        period_in = WIDTH'(v);
        period_we = 1'b1;
    endtask

    task automatic wr_presc(int v);
        @(negedge clk);
        clr();
        presc_in = PRESC_W'(v);
        presc_we = 1'b1;
    endtask

    task automatic wr_mode(int v);
        @(negedge clk);
        clr();
        mode_in = v[0];
        mode_we = 1'b1;
    endtask

    task automatic wr_duty(int sel, int v);
        @(negedge clk);
        clr();
        duty_sel = CH_W'(sel);
        duty_in = WIDTH'(v);
        duty_we = 1'b1;
    endtask

    task automatic check_idle(string name);
        n_cmp++;
        if (pwm_out !== '0 || frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL %s pwm_out=%b frame_start=%b required 0/0",
                     name, pwm_out, frame_start);
        end
    endtask

    initial begin
        #2;
        check_idle("reset_state");
        idle(2);
        rst_n = 1'b1;

        // edge, period 9, duty0 3
        wr_period(9);
        wr_presc(0);
        wr_mode(0);
        wr_duty(0, 3);
        idle(1);
        enable = 1'b1;
        idle(25);
        wr_duty(0, 7);
        idle(30);

        // center, period 4, duty1 2
        wr_period(4);
        wr_mode(1);
        wr_duty(1, 2);
        idle(40);

        // prescaled edge, then duty extremes
        wr_mode(0);
        wr_presc(2);
        wr_period(3);
        wr_duty(2, 2);
        idle(40);
        wr_duty(2, 0);
        idle(30);
        wr_duty(2, 4);
        idle(30);

        // drop and restore enable mid-frame with a staged change
        idle(5);
        enable = 1'b0;
        wr_duty(0, 1);
        idle(4);
        enable = 1'b1;
        idle(30);

        // out-of-range channel select, then period 0
        wr_duty(NCH, 9);
        wr_presc(0);
        wr_period(0);
        wr_duty(0, 1);
        idle(20);

        // asynchronous reset while outputs are active
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        idle(2);
        rst_n = 1'b1;
        enable = 1'b1;
        idle(10);

        // randomized traffic
        repeat (3000) begin
            @(negedge clk);
            clr();
            if ($urandom_range(0, 15) == 0) begin
                period_in = WIDTH'($urandom_range(0, 12));
                period_we = 1'b1;
            end
            if ($urandom_range(0, 23) == 0) begin
                presc_in = PRESC_W'($urandom_range(0, 3));
                presc_we = 1'b1;
            end
            if ($urandom_range(0, 23) == 0) begin
                mode_in = 1'($urandom_range(0, 1));
                mode_we = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) begin
                duty_sel = CH_W'($urandom_range(0, 3));
                duty_in = WIDTH'($urandom_range(0, 14));
                duty_we = 1'b1;
            end
            if ($urandom_range(0, 31) == 0) begin
                pol_in = NCH'($urandom_range(0, 7));
                pol_we = 1'b1;
            end
            if ($urandom_range(0, 99) == 0)
                enable = ~enable;
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
